// File: rtl/img_stream_framer_if.sv
// Word-stream handshake bundle between the host/DMA side and the decoder inport.
// slave: framer side (takes in_*, drives out_* and upstream_stall).
// master: producer/consumer side (drives in_* and downstream_stall).
interface img_stream_framer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                upstream_stall;
    logic [DATA_W-1:0]   out_data;
    logic [DATA_W/8-1:0] out_strb;
    logic                out_last;
    logic                out_valid;
    logic                downstream_stall;

    modport slave (
        input  in_data, in_valid, downstream_stall,
        output upstream_stall, out_data, out_strb, out_last, out_valid
    );

    modport master (
        output in_data, in_valid, downstream_stall,
        input  upstream_stall, out_data, out_strb, out_last, out_valid
    );
endinterface

// File: rtl/img_stream_framer.sv
// Length-prefixed word stream to strobed, last-tagged beats for the JPEG decoder core.
// Latency: payload word accepted in cycle N is presented in N+1 (empty buffer); headers never emitted.
// Backpressure: 2-entry skid buffer; upstream_stall is registered and high only while both entries are full.
// Ports: clock/reset (sync, active-high); bus = stream interface (slave side);
//        core_reset/err_len pulse on zero/illegal headers; frame_done/frame_count track completed frames;
//        busy = mid-frame or beats still buffered.
module img_stream_framer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 24,
    parameter int CNT_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    img_stream_framer_if.slave bus,
    output logic               core_reset,
    output logic               frame_done,
    output logic [CNT_W-1:0]   frame_count,
    output logic               err_len,
    output logic               busy
);
    localparam int BYTES = DATA_W / 8;
    localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  remaining;

    // Skid buffer: entry 0 is always the head, entry 1 the follower.
    logic [DATA_W-1:0] ent_dat  [2];
    logic [BYTES-1:0]  ent_strb [2];
    logic              ent_last [2];
    logic [1:0]        count;

    logic              accept;
    logic              push;
    logic              pop;
    logic              hdr_bad;
    logic              hdr_zero;
    logic [BYTES-1:0]  strb_calc;
    logic              last_calc;
    logic [LEN_W-1:0]  rem_nxt;
    logic [1:0]        count_nxt;
    logic [1:0]        after_pop;
    logic              wr_idx;

    assign accept   = bus.in_valid && !bus.upstream_stall;
    assign push     = accept && (state == PAYLOAD);
    assign pop      = bus.out_valid && !bus.downstream_stall;
    // Any set bit above the length field makes the header illegal; the shift
    // yields zero when the length field spans the whole word.
    assign hdr_bad  = |(bus.in_data >> LEN_W);
    assign hdr_zero = (bus.in_data[LEN_W-1:0] == '0);

    always_comb begin
        strb_calc = '0;
        // Byte i is valid while more than i bytes remain; this saturates to
        // all ones for a full word.
        for (int i = 0; i < BYTES; i++) begin
            strb_calc[i] = (remaining > LEN_W'(i));
        end
        last_calc = (remaining <= BYTES_L);
        rem_nxt   = (remaining > BYTES_L) ? (remaining - BYTES_L) : '0;
        after_pop = count - 2'(pop);
        count_nxt = after_pop + 2'(push);
        // A push lands right behind whatever survives this cycle's pop.
        wr_idx    = after_pop[0];
    end

    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = ent_dat[0];
    assign bus.out_strb  = ent_strb[0];
    assign bus.out_last  = ent_last[0];
    assign busy          = (state == PAYLOAD) || (count != 2'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            remaining          <= '0;
            count              <= '0;
            bus.upstream_stall <= 1'b0;
            ent_dat[0]         <= '0;
            ent_dat[1]         <= '0;
            ent_strb[0]        <= '0;
            ent_strb[1]        <= '0;
            ent_last[0]        <= 1'b0;
            ent_last[1]        <= 1'b0;
            core_reset         <= 1'b0;
            err_len            <= 1'b0;
            frame_done         <= 1'b0;
            frame_count        <= '0;
        end else begin
            core_reset <= 1'b0;
            err_len    <= 1'b0;
            frame_done <= pop && ent_last[0];
            if (pop && ent_last[0]) begin
                frame_count <= frame_count + CNT_W'(1);
            end

            count              <= count_nxt;
            bus.upstream_stall <= (count_nxt == 2'd2);

            if (pop) begin
                ent_dat[0]  <= ent_dat[1];
                ent_strb[0] <= ent_strb[1];
                ent_last[0] <= ent_last[1];
            end
            // Placed after the shift so a push into slot 0 overrides it.
            if (push) begin
                ent_dat[wr_idx]  <= bus.in_data;
                ent_strb[wr_idx] <= strb_calc;
                ent_last[wr_idx] <= last_calc;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            err_len <= 1'b1;
                        end else if (hdr_zero) begin
                            core_reset <= 1'b1;
                        end else begin
                            remaining <= bus.in_data[LEN_W-1:0];
                            state     <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        remaining <= rem_nxt;
                        if (last_calc) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_img_stream_framer.sv
// Directed bench for img_stream_framer: 32-bit instance checked against a beat scoreboard,
// plus a 64-bit instance for header-error and wide-strobe cases.
module tb_img_stream_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    img_stream_framer_if #(.DATA_W(32)) b32 ();
    img_stream_framer_if #(.DATA_W(64)) b64 ();

    logic        cr32, fd32, el32, bz32;
    logic [15:0] fc32;
    logic        cr64, fd64, el64, bz64;
    logic [15:0] fc64;

    img_stream_framer #(.DATA_W(32), .LEN_W(24), .CNT_W(16)) u32 (
        .clock(clk), .reset(rst), .bus(b32),
        .core_reset(cr32), .frame_done(fd32), .frame_count(fc32),
        .err_len(el32), .busy(bz32)
    );

    img_stream_framer #(.DATA_W(64), .LEN_W(24), .CNT_W(16)) u64 (
        .clock(clk), .reset(rst), .bus(b64),
        .core_reset(cr64), .frame_done(fd64), .frame_count(fc64),
        .err_len(el64), .busy(bz64)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    mdl_cnt = 0;
    bit    done_pend = 1'b0;
    bit    prev_stalled = 1'b0;
    beat_t prev_beat;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the word until accepted, then drops in_valid at the same instant
    // so a following send keeps in_valid continuously high.
    task automatic send(input logic [31:0] d);
        bit acc;
        int guard;
        guard = 0;
        b32.in_data  = d;
        b32.in_valid = 1'b1;
        do begin
            acc = !b32.upstream_stall;
            step();
            guard++;
        end while (!acc && guard < 100);
        chk("accept", 128'(acc), 128'(1));
        b32.in_valid = 1'b0;
    endtask

    task automatic send_pay(input logic [31:0] d, input logic [3:0] s, input logic l);
        beat_t b;
        b = {d, s, l};
        exp_q.push_back(b);
        send(d);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bz32 !== 1'b0) && guard < 100) begin
            step();
            guard++;
        end
        step();
        chk("drain", 128'({exp_q.size() == 0, bz32}), 128'(2'b10));
    endtask

    task automatic chk_reset_state(input string tag);
        chk(tag, 128'({b32.out_valid, b32.upstream_stall, cr32, fd32, el32, bz32,
                       fc32, b32.out_data, b32.out_strb, b32.out_last}), 128'(0));
    endtask

    // Output monitor: beats, frame_done timing, frame_count and stall stability.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (rst !== 1'b0) begin
            done_pend    = 1'b0;
            prev_stalled = 1'b0;
            mdl_cnt      = 0;
        end else begin
            cur = {b32.out_data, b32.out_strb, b32.out_last};
            if (done_pend) mdl_cnt++;
            chk("frame_done", 128'(fd32), 128'(done_pend));
            chk("frame_count", 128'(fc32), 128'(16'(mdl_cnt)));
            if (prev_stalled && b32.out_valid) chk("hold", 128'(cur), 128'(prev_beat));
            prev_stalled = b32.out_valid && b32.downstream_stall;
            prev_beat    = cur;
            done_pend    = 1'b0;
            if (b32.out_valid && !b32.downstream_stall) begin
                chk("beat_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat", 128'(cur), 128'(e));
                    done_pend = e.last;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        b32.in_data = '0; b32.in_valid = 1'b0; b32.downstream_stall = 1'b0;
        b64.in_data = '0; b64.in_valid = 1'b0; b64.downstream_stall = 1'b0;
        step(3);
        chk_reset_state("reset_state");
        rst = 1'b0;
        step();

        // Frame of 10 bytes: strobes 1111/1111/0011, last on third beat.
        send(32'd10);
        send_pay(32'hA0A1_A2A3, 4'hF, 1'b0);
        send_pay(32'hB0B1_B2B3, 4'hF, 1'b0);
        send_pay(32'hC0C1_C2C3, 4'h3, 1'b1);
        drain();
        chk("count_after_f1", 128'(fc32), 128'(1));
        chk("busy_after_f1", 128'(bz32), 128'(0));

        // Zero-length header requests a decoder reset, no beat, no frame.
        send(32'd0);
        chk("core_reset_hi", 128'({cr32, b32.out_valid}), 128'(2'b10));
        step();
        chk("core_reset_lo", 128'(cr32), 128'(0));
        chk("count_after_zero", 128'(fc32), 128'(1));
        send(32'd4);
        send_pay(32'hD0D1_D2D3, 4'hF, 1'b1);
        drain();
        chk("count_after_f2", 128'(fc32), 128'(2));

        // 16-byte frame with a 5-cycle downstream stall starting at beat 2.
        send(32'd16);
        send_pay(32'hE000_0000, 4'hF, 1'b0);
        fork
            begin
                send_pay(32'hE111_1111, 4'hF, 1'b0);
                send_pay(32'hE222_2222, 4'hF, 1'b0);
                send_pay(32'hE333_3333, 4'hF, 1'b1);
            end
            begin
                step();
                b32.downstream_stall = 1'b1;
                step(4);
                chk("upstream_stall_full", 128'({b32.upstream_stall, b32.out_valid}), 128'(2'b11));
                step();
                b32.downstream_stall = 1'b0;
            end
        join
        drain();
        chk("count_after_f3", 128'(fc32), 128'(3));
        chk("stall_released", 128'(b32.upstream_stall), 128'(0));

        // Reset mid-frame with two beats buffered.
        send(32'd12);
        b32.downstream_stall = 1'b1;
        send_pay(32'hF000_0000, 4'hF, 1'b0);
        send_pay(32'hF111_1111, 4'hF, 1'b0);
        step();
        chk("pre_reset_full", 128'(b32.upstream_stall), 128'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        b32.downstream_stall = 1'b0;
        chk_reset_state("midframe_reset");
        send(32'd4);
        send_pay(32'h6060_6060, 4'hF, 1'b1);
        drain();
        chk("count_after_reset", 128'(fc32), 128'(1));

        // Back-to-back frames with in_valid held high throughout.
        send(32'd4);
        send_pay(32'h1111_0000, 4'hF, 1'b1);
        send(32'd4);
        send_pay(32'h2222_0000, 4'hF, 1'b1);
        drain();
        chk("count_b2b", 128'(fc32), 128'(3));

        // 64-bit instance: illegal header, then an 8-byte frame.
        b64.in_data  = 64'h0000_0000_0100_0000;
        b64.in_valid = 1'b1;
        step();
        chk("w64_err_len", 128'({el64, bz64, b64.out_valid}), 128'(3'b100));
        b64.in_data = 64'd8;
        step();
        chk("w64_hdr", 128'({el64, bz64}), 128'(2'b01));
        b64.in_data = 64'hDEAD_BEEF_0123_4567;
        step();
        b64.in_valid = 1'b0;
        chk("w64_beat", 128'({b64.out_valid, b64.out_strb, b64.out_last, b64.out_data}),
            128'({1'b1, 8'hFF, 1'b1, 64'hDEAD_BEEF_0123_4567}));
        step();
        chk("w64_done", 128'({fd64, fc64, b64.out_valid, bz64}), 128'({1'b1, 16'd1, 1'b0, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
